// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: FSM states, the AES reduction polynomial and
// a width-generic xtime helper used by the FFMul family.
package gf_pkg;

  localparam int unsigned GF_MAX_W = 32;
  localparam logic [7:0]  GF_POLY_AES = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf_state_e;

  // Multiply p by x modulo (x^width + poly); bits at or above width are zero.
  function automatic logic [GF_MAX_W-1:0] gf_xtime(
    input logic [GF_MAX_W-1:0] p,
    input logic [GF_MAX_W-1:0] poly,
    input int                  width
  );
    logic [GF_MAX_W-1:0] r;
    logic                msb;
    r   = '0;
    msb = 1'b0;
    for (int i = 0; i < int'(GF_MAX_W); i++) begin
      if (i == width - 1) msb = p[i];
      if ((i > 0) && (i < width)) r[i] = p[i-1];
    end
    if (msb) r = r ^ poly;
    return r;
  endfunction

endpackage

// File: rtl/gf_mul_serial_digit_step.sv
// One clock's worth of interleaved shift-and-add: DIGIT chained xtime/add
// steps consuming the top DIGIT bits of b, most significant first.
module gf_digit_step
  import gf_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter int unsigned      DIGIT = 1,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(GF_POLY_AES)
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [DIGIT-1:0] b_top_i,
  output logic [WIDTH-1:0] p_next_c
);

  logic [WIDTH-1:0] acc;

  always_comb begin
    acc = p_i;
    for (int i = int'(DIGIT) - 1; i >= 0; i--) begin
      acc = WIDTH'(gf_xtime(GF_MAX_W'(acc), GF_MAX_W'(POLY), int'(WIDTH)))
            ^ (b_top_i[i] ? a_i : '0);
    end
    p_next_c = acc;
  end

endmodule

// File: rtl/gf_mul_serial.sv
// Sequential GF(2^WIDTH) multiplier, DIGIT bits of b per cycle, with
// valid/ready on both sides and a fixed WIDTH/DIGIT-cycle compute phase.
module gf_mul_serial
  import gf_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned POLY  = 32'(GF_POLY_AES),
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             busy
);

  localparam int unsigned DIV_SAFE = (DIGIT < 1) ? 1 : DIGIT;
  localparam int unsigned N        = WIDTH / DIV_SAFE;
  localparam int unsigned CNT_W    = $clog2(N + 1);
  localparam logic [WIDTH-1:0] POLY_W = WIDTH'(POLY);

  if ((DIGIT < 1) || ((WIDTH % DIV_SAFE) != 0) ||
      (64'(POLY) >= (64'd1 << WIDTH)) || (WIDTH > GF_MAX_W)) begin : g_param_check
    $error("gf_mul_serial: illegal WIDTH/DIGIT/POLY combination");
  end

  gf_state_e        state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] p_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_p_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  gf_digit_step #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT),
    .POLY  (POLY_W)
  ) u_step (
    .p_i      (p_q),
    .a_i      (a_q),
    .b_top_i  (b_q[WIDTH-1 -: DIGIT]),
    .p_next_c (p_d)
  );

  // Handshake/compute FSM; in_ready mirrors IDLE so in_valid alone starts an op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      out_p_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            p_q        <= '0;
            cnt_q      <= CNT_W'(N);
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          p_q   <= p_d;
          b_q   <= b_q << DIGIT;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= DONE;
            out_p_q     <= p_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gf_mul_serial.sv
// Directed bench for gf_mul_serial: four instances (DIGIT 1/4/8, WIDTH 4)
// share the operand and handshake inputs.
module tb_gf_mul_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;

  logic       rdy1, vld1, busy1;
  logic [7:0] p1;
  logic       rdy4, vld4, busy4;
  logic [7:0] p4;
  logic       rdy8, vld8, busy8;
  logic [7:0] p8;
  logic       rdyw, vldw, busyw;
  logic [3:0] pw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf_mul_serial #(.WIDTH(8), .POLY(32'h1B), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
    .out_valid(vld1), .out_ready(out_ready), .out_p(p1), .busy(busy1));
  gf_mul_serial #(.WIDTH(8), .POLY(32'h1B), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_a(in_a), .in_b(in_b),
    .out_valid(vld4), .out_ready(out_ready), .out_p(p4), .busy(busy4));
  gf_mul_serial #(.WIDTH(8), .POLY(32'h1B), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_a(in_a), .in_b(in_b),
    .out_valid(vld8), .out_ready(out_ready), .out_p(p8), .busy(busy8));
  gf_mul_serial #(.WIDTH(4), .POLY(32'h3), .DIGIT(1)) dutw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyw), .in_a(in_a[3:0]),
    .in_b(in_b[3:0]), .out_valid(vldw), .out_ready(out_ready), .out_p(pw), .busy(busyw));

  // LSB-first software product, independent of the MSB-first hardware order.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                        input int w, input logic [7:0] poly);
    logic [7:0] r, x, mask;
    logic       top;
    r    = 8'h00;
    x    = a;
    mask = 8'((16'd1 << w) - 16'd1);
    for (int i = 0; i < w; i++) begin
      if (((b >> i) & 8'h01) != 8'h00) r = r ^ x;
      top = ((x >> (w - 1)) & 8'h01) != 8'h00;
      x   = ((x << 1) & mask) ^ (top ? poly : 8'h00);
    end
    return r;
  endfunction

  // Launch one op on all instances, record first-valid cycle and product, then release.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                       output logic [7:0] q1, output logic [7:0] q4, output logic [7:0] q8,
                       output logic [3:0] qw, output int l1, output int l4,
                       output int l8, output int lw);
    l1 = 0; l4 = 0; l8 = 0; lw = 0;
    q1 = 8'h00; q4 = 8'h00; q8 = 8'h00; qw = 4'h0;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (vld1 && l1 == 0) begin l1 = cyc; q1 = p1; end
      if (vld4 && l4 == 0) begin l4 = cyc; q4 = p4; end
      if (vld8 && l8 == 0) begin l8 = cyc; q8 = p8; end
      if (vldw && lw == 0) begin lw = cyc; qw = pw; end
      if (l1 != 0 && l4 != 0 && l8 != 0 && lw != 0) break;
      @(posedge clk); #1;
    end
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 8'h00; in_b = 8'h00;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", rdy1); end
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", vld1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (p1 !== 8'h00) begin errors++; $display("FAIL reset_out_p: got %h expected 00", p1); end
    checks++; if (rdy4 !== 1'b1 || rdy8 !== 1'b1 || rdyw !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_variants: got %b%b%b expected 111", rdy4, rdy8, rdyw);
    end
  endtask

  task automatic test_latency;
    logic [7:0] q1, q4, q8;
    logic [3:0] qw;
    int l1, l4, l8, lw;
    do_op(8'h57, 8'h83, 0, q1, q4, q8, qw, l1, l4, l8, lw);
    checks++; if (q1 !== 8'hC1) begin errors++; $display("FAIL d1_57x83: got %h expected c1", q1); end
    checks++; if (l1 != 9) begin errors++; $display("FAIL d1_latency: got %0d expected 9", l1); end
    checks++; if (q4 !== 8'hC1) begin errors++; $display("FAIL d4_57x83: got %h expected c1", q4); end
    checks++; if (l4 != 3) begin errors++; $display("FAIL d4_latency: got %0d expected 3", l4); end
    checks++; if (q8 !== 8'hC1) begin errors++; $display("FAIL d8_57x83: got %h expected c1", q8); end
    checks++; if (l8 != 2) begin errors++; $display("FAIL d8_latency: got %0d expected 2", l8); end
  endtask

  task automatic test_vectors;
    logic [7:0] va[4] = '{8'h53, 8'h02, 8'hFF, 8'h00};
    logic [7:0] vb[4] = '{8'hCA, 8'h80, 8'h01, 8'hA5};
    logic [7:0] ve[4] = '{8'h01, 8'h1B, 8'hFF, 8'h00};
    logic [7:0] q1, q4, q8;
    logic [3:0] qw;
    int l1, l4, l8, lw;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], i, q1, q4, q8, qw, l1, l4, l8, lw);
      checks++; if (q1 !== ve[i]) begin errors++; $display("FAIL vec%0d_d1: got %h expected %h", i, q1, ve[i]); end
      checks++; if (l1 != 9) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 9", i, l1); end
      checks++; if (q4 !== ve[i] || q8 !== ve[i]) begin
        errors++; $display("FAIL vec%0d_d4_d8: got %h/%h expected %h", i, q4, q8, ve[i]);
      end
    end
  endtask

  task automatic test_width4;
    logic [7:0] q1, q4, q8;
    logic [3:0] qw;
    int l1, l4, l8, lw;
    // (x^2+x+1)(x^3+x+1) = x^5+x^4+1 = x^2 mod x^4+x+1
    do_op(8'h07, 8'h0B, 0, q1, q4, q8, qw, l1, l4, l8, lw);
    checks++; if (qw !== 4'h4) begin errors++; $display("FAIL w4_7x b: got %h expected 4", qw); end
    checks++; if (lw != 5) begin errors++; $display("FAIL w4_latency: got %0d expected 5", lw); end
    do_op(8'h08, 8'h02, 0, q1, q4, q8, qw, l1, l4, l8, lw);
    checks++; if (qw !== 4'h3) begin errors++; $display("FAIL w4_8x2: got %h expected 3", qw); end
  endtask

  task automatic test_backpressure;
    int  l;
    l = 0;
    in_a = 8'h57; in_b = 8'h83; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 40 && l == 0; c++) begin
      if (vld1) l = c;
      else begin @(posedge clk); #1; end
    end
    checks++; if (l != 9) begin errors++; $display("FAIL bp_latency: got %0d expected 9", l); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (vld1 !== 1'b1 || p1 !== 8'hC1 || rdy1 !== 1'b0) begin
        errors++; $display("FAIL bp_stall%0d: got v=%b p=%h r=%b expected v=1 p=c1 r=0", k, vld1, p1, rdy1);
      end
      if (k == 5) break;
      in_valid = k[0]; in_a = 8'hFF; in_b = 8'hFF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (vld1 !== 1'b0 || rdy1 !== 1'b1) begin
      errors++; $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", vld1, rdy1);
    end
    checks++; if (p1 !== 8'hC1) begin errors++; $display("FAIL bp_retain: got %h expected c1", p1); end
    l = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (vld1 !== 1'b0 || rdy1 !== 1'b1 || busy1 !== 1'b0) l++;
    end
    checks++; if (l != 0) begin errors++; $display("FAIL bp_no_capture: got %0d bad cycles expected 0", l); end
  endtask

  task automatic test_back_to_back;
    int t[3];
    int n;
    n = 0;
    t = '{0, 0, 0};
    out_ready = 1'b1; in_a = 8'h53; in_b = 8'hCA; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (vld1 && n < 3) begin
        checks++; if (p1 !== 8'h01) begin errors++; $display("FAIL b2b_p%0d: got %h expected 01", n, p1); end
        t[n] = cyc;
        n++;
      end
    end
    in_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n); end
    checks++; if (t[1] - t[0] != 10 || t[2] - t[1] != 10) begin
      errors++; $display("FAIL b2b_period: got %0d,%0d expected 10,10", t[1] - t[0], t[2] - t[1]);
    end
  endtask

  task automatic test_reset_mid_busy;
    logic [7:0] q1, q4, q8;
    logic [3:0] qw;
    int l1, l4, l8, lw;
    bit seen;
    in_a = 8'h57; in_b = 8'h83; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy1 !== 1'b1 || vld1 !== 1'b0) begin
      errors++; $display("FAIL rst_busy_before: got busy=%b v=%b expected busy=1 v=0", busy1, vld1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (rdy1 !== 1'b1 || busy1 !== 1'b0 || vld1 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got r=%b busy=%b v=%b expected 1 0 0", rdy1, busy1, vld1);
    end
    checks++; if (p1 !== 8'h00) begin errors++; $display("FAIL rst_mid_out_p: got %h expected 00", p1); end
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (vld1 !== 1'b0) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rst_dropped_op: got out_valid=1 expected 0"); end
    do_op(8'h57, 8'h13, 0, q1, q4, q8, qw, l1, l4, l8, lw);
    checks++; if (q1 !== 8'hFE) begin errors++; $display("FAIL rst_next_op: got %h expected fe", q1); end
    checks++; if (l1 != 9) begin errors++; $display("FAIL rst_next_latency: got %0d expected 9", l1); end
  endtask

  task automatic test_random;
    logic [7:0] a, b, e8;
    logic [7:0] q1, q4, q8, ew;
    logic [3:0] qw;
    int l1, l4, l8, lw;
    for (int i = 0; i < 120; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      do_op(a, b, int'($urandom_range(0, 3)), q1, q4, q8, qw, l1, l4, l8, lw);
      e8 = gf_ref(a, b, 8, 8'h1B);
      ew = gf_ref(a & 8'h0F, b & 8'h0F, 4, 8'h03);
      checks++;
      if (q1 !== e8 || q4 !== e8 || q8 !== e8 || {4'h0, qw} !== ew) begin
        errors++;
        $display("FAIL rand_%h_%h: got %h/%h/%h/%h expected %h/%h/%h/%h",
                 a, b, q1, q4, q8, qw, e8, e8, e8, ew[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_width4();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
